ysyx_23060180_data_sram: RTL
============================

Name: ysyx_23060180_data_sram

Overview:
- Memory-side slave that sits directly downstream of the CPU core's single shared memory port and serves its instruction-fetch, load and store requests.
- Internal word-organised SRAM with fixed 1-cycle read latency, byte-lane alignment for sub-word accesses, and address-range and alignment checking with sticky error capture.
- Power-up fill sweep; `init_done` holds the core in reset until memory is initialised.
- Backdoor program port for loading images.

Parameters:
- BASE_ADDR, 32'h80000000, byte address of word 0.
- ADDR_W, 12, word-index width; DEPTH = 2**ADDR_W words.
- INIT_FILL, 32'h00000000, value written to every word during the init sweep.

Ports:
- clk  in  1  clock
- rstn_in  in  1  reset, asynchronous, active-low
- mem_rd  in  1  read request this cycle
- mem_wr  in  1  write request this cycle
- mem_raddr  in  32  byte address for both read and write
- mem_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- mem_wbit_en  in  4  store size in bytes: 1, 2 or 4; other values are illegal
- mem_rdata  out  32  read data, right-aligned
- init_done  out  1  memory initialised; drives the core's rstn_in
- prog_en  in  1  backdoor word write
- prog_addr  in  ADDR_W  backdoor word index
- prog_data  in  32  backdoor word data
- err_valid  out  1  sticky error flag
- err_code  out  2  error code: 0 RANGE, 1 MISALIGN, 2 BADSIZE, 3 COLLIDE
- err_addr  out  32  byte address of the first captured error
- err_clr  in  1  clears the error capture

Behaviour:
- Reset (async assert) forces these values:
  - state = INIT, init_cnt = 0
  - mem_rdata = 0, init_done = 0
  - err_valid = 0, err_code = 0, err_addr = 0
  - SRAM contents are not reset.
- INIT state:
  - Each clock writes INIT_FILL to word init_cnt, then increments init_cnt.
  - After the write to word DEPTH-1, go to RUN.
  - init_done is 1 from that same edge onward, i.e. DEPTH edges after reset release.
  - In INIT, mem_rd, mem_wr and prog_en are ignored: no errors raised, mem_rdata holds 0.
- Reset asserted mid-operation returns to INIT and restarts the sweep from word 0.
- RUN state:
  - off = mem_raddr - BASE_ADDR, computed as 32-bit unsigned.
  - in_range = off < 4*DEPTH.
  - idx = off[ADDR_W+1:2], lane = off[1:0].
- Read (mem_rd=1 at edge N):
  - mem_rdata is updated at edge N+1, so it is valid in the cycle after the request.
  - Value = word[idx] >> (8*lane), upper bytes zero-filled.
  - The access never crosses into the next word.
  - Sign extension and byte/half selection are the consumer's job.
  - Out-of-range read: mem_rdata = 0 and a RANGE error is raised.
  - mem_rdata holds its value in cycles with no read.
  - Reads never raise MISALIGN.
- Write (mem_wr=1), size from mem_wbit_en:

  | Size | Byte strobes | Legal lanes |
  |---|---|---|
  | 1 (byte) | 4'b0001 << lane | any |
  | 2 (half) | 4'b0011 << lane | 0 or 2 |
  | 4 (word) | 4'b1111 | 0 only |

  - Data is shifted left by 8*lane before strobing.
  - Illegal size: BADSIZE error, no write.
  - Illegal lane for the size: MISALIGN error, no write.
  - Out-of-range: RANGE error, no write.
  - When several checks fail, the single reported code follows RANGE > BADSIZE > MISALIGN.
- Simultaneous mem_rd and mem_wr: one address, read-before-write; the read returns pre-write contents and the write commits at the same edge.
- prog_en in RUN writes the full word prog_data to prog_addr.
  - If a legal core write hits the same edge, prog_en wins, the core write is dropped, and a COLLIDE error is raised with err_addr = mem_raddr.
  - A core write in the same edge as prog_en is dropped regardless of which word it targets.
- Error capture:
  - The first error while err_valid=0 loads err_valid=1, err_code and err_addr = mem_raddr at that edge.
  - Later errors are ignored while err_valid=1.
  - err_clr clears err_valid and err_code to 0 at the next edge.
  - If err_clr and a new error occur in the same edge, the new error is captured.
  - Errors never stall or abort operation.

Test Plan:
- ADDR_W=4, reset release -> init_done rises exactly 16 edges later. Then read 0x80000000 -> mem_rdata=0x00000000 one cycle after the request.
- prog word 0 = 0x11223344; read 0x80000001 -> 0x00112233; read 0x80000002 -> 0x00001122; read 0x80000003 -> 0x00000011; no error.
- Write wbit_en=1, addr 0x80000003, wdata 0x000000AB -> read 0x80000000 gives 0xAB223344. Write wbit_en=2, addr 0x80000002, wdata 0x0000BEEF -> 0xBEEF3344.
- Write wbit_en=2 at 0x80000003 -> word unchanged; err_valid=1, code=1, addr=0x80000003. Then wbit_en=3 write -> capture unchanged. err_clr -> err_valid=0. Next bad access is captured.
- Read 0x7FFFFFFC -> mem_rdata=0, err code 0, err_addr 0x7FFFFFFC. Write to 0x80000040 (ADDR_W=4) -> no write, RANGE error.
- Word 1 = 0; mem_rd+mem_wr word 0x80000004 with 0xDEADBEEF -> rdata=0x00000000. Next read -> 0xDEADBEEF. prog_en with core write in the same edge -> prog data kept, COLLIDE captured. Reset mid-sweep -> init_cnt restarts at 0.

Source files
------------

// File: rtl/ysyx_23060180_data_sram.sv
// Data-side SRAM slave for the core's shared memory port: 1-cycle reads, sub-word
// lane alignment, power-up fill sweep, backdoor program port and sticky error capture.
module ysyx_23060180_data_sram #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] INIT_FILL = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rstn_in,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [31:0]       mem_raddr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wbit_en,
   output logic [31:0]       mem_rdata,
   output logic              init_done,
   input  logic              prog_en,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [31:0]       prog_data,
   output logic              err_valid,
   output logic [1:0]        err_code,
   output logic [31:0]       err_addr,
   input  logic              err_clr
);
   localparam int DEPTH = 1 << ADDR_W;

   localparam logic ST_INIT = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam logic [1:0] E_RANGE    = 2'd0;
   localparam logic [1:0] E_MISALIGN = 2'd1;
   localparam logic [1:0] E_BADSIZE  = 2'd2;
   localparam logic [1:0] E_COLLIDE  = 2'd3;

   logic [31:0] mem [DEPTH];

   logic              state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_valid_q, err_valid_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [31:0]       err_addr_q, err_addr_d;

   logic              run;
   logic [31:0]       off;
   logic              in_range;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        lane;
   logic              size_ok, lane_ok;
   logic [3:0]        wstrb;
   logic [31:0]       wdata_sh;
   logic              core_we;
   logic              err_hit;
   logic [1:0]        err_sel;

   always_comb begin
      run      = (state_q == ST_RUN);
      off      = mem_raddr - BASE_ADDR;
      in_range = ((off >> (ADDR_W + 2)) == 32'd0);
      idx      = off[ADDR_W+1:2];
      lane     = off[1:0];
      wdata_sh = mem_wdata << {lane, 3'b000};

      size_ok = 1'b1;
      lane_ok = 1'b0;
      wstrb   = 4'b0000;
      case (mem_wbit_en)
         4'd1: begin lane_ok = 1'b1;            wstrb = 4'b0001 << lane; end
         4'd2: begin lane_ok = ~lane[0];        wstrb = 4'b0011 << lane; end
         4'd4: begin lane_ok = (lane == 2'd0);  wstrb = 4'b1111;         end
         default: size_ok = 1'b0;
      endcase

      // Backdoor writes always win; a colliding core write is dropped.
      core_we = run & mem_wr & in_range & size_ok & lane_ok & ~prog_en;

      err_hit = 1'b0;
      err_sel = E_RANGE;
      if (run) begin
         if ((mem_rd | mem_wr) & ~in_range) begin
            err_hit = 1'b1; err_sel = E_RANGE;
         end else if (mem_wr & ~size_ok) begin
            err_hit = 1'b1; err_sel = E_BADSIZE;
         end else if (mem_wr & ~lane_ok) begin
            err_hit = 1'b1; err_sel = E_MISALIGN;
         end else if (mem_wr & prog_en) begin
            err_hit = 1'b1; err_sel = E_COLLIDE;
         end
      end

      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (!run) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (&init_cnt_q) state_d = ST_RUN;
      end

      rdata_d = rdata_q;
      if (run && mem_rd) rdata_d = in_range ? (mem[idx] >> {lane, 3'b000}) : 32'd0;

      err_valid_d = err_valid_q;
      err_code_d  = err_code_q;
      err_addr_d  = err_addr_q;
      if (err_hit && (!err_valid_q || err_clr)) begin
         err_valid_d = 1'b1;
         err_code_d  = err_sel;
         err_addr_d  = mem_raddr;
      end else if (err_clr) begin
         err_valid_d = 1'b0;
         err_code_d  = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         rdata_q     <= 32'd0;
         err_valid_q <= 1'b0;
         err_code_q  <= 2'd0;
         err_addr_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         rdata_q     <= rdata_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         err_addr_q  <= err_addr_d;
      end
   end

   // Storage carries no reset; the init sweep provides defined contents.
   always_ff @(posedge clk) begin
      if (!run) mem[init_cnt_q] <= INIT_FILL;
      if (run && prog_en) mem[prog_addr] <= prog_data;
      for (int b = 0; b < 4; b++) begin
         if (core_we && wstrb[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
   end

   assign mem_rdata = rdata_q;
   assign init_done = run;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign err_addr  = err_addr_q;
endmodule
